gal_row_reader: RTL and testbench



---
 rtl/gal_row_reader.sv | 197 +++++++++++++++++++
 tb/tb_gal_row_reader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gal_row_reader.sv
// gal_row_reader: reads one GAL fuse row over the serial programming pins.
// A row address is shifted out on SDIN/SCLK and then strobed into the
// device with STB low. The row is then clocked back in from SDOUT and
// handed to the consumer as bytes over a valid/ready stream.
module gal_row_reader #(
    parameter int ROW_BITS   = 64,
    parameter int ADDR_BITS  = 6,
    parameter int DIV        = 4,
    parameter int STB_CYCLES = 8
) (
    input  logic                 C,
    input  logic                 RN,
    input  logic                 START,
    input  logic [ADDR_BITS-1:0] ADDR,
    output logic                 BUSY,
    output logic [7:0]           D,
    output logic                 DV,
    input  logic                 DR,
    output logic                 DL,
    output logic                 SDIN,
    output logic                 SCLK,
    output logic                 STB,
    output logic                 PV,
    input  logic                 SDOUT
);

    localparam int CNT_MAX = (DIV > STB_CYCLES) ? DIV : STB_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(ROW_BITS + 1);
    localparam int AIDX_W  = $clog2(ADDR_BITS + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  STB_LAST  = CNT_W'(STB_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]  ROW_LAST  = BIT_W'(ROW_BITS - 1);
    localparam logic [BIT_W-1:0]  ROW_DONE  = BIT_W'(ROW_BITS);
    localparam logic [AIDX_W-1:0] AIDX_ONE  = AIDX_W'(1);
    localparam logic [AIDX_W-1:0] ADDR_LAST = AIDX_W'(ADDR_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_STROBE,
        S_READ,
        S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sclk_q, sclk_d;
    logic [ADDR_BITS-1:0] addrSh_q, addrSh_d;
    logic [AIDX_W-1:0]    aIdx_q, aIdx_d;
    logic [BIT_W-1:0]     bitIdx_q, bitIdx_d;
    logic [7:0]           acc_q, acc_d;
    logic [7:0]           data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 dl_q, dl_d;

    logic                 phaseEnd;
    logic                 stbEnd;
    logic                 byteEnd;
    logic [2:0]           bitPos;

    assign phaseEnd = (cnt_q == DIV_LAST);
    assign stbEnd   = (cnt_q == STB_LAST);
    assign bitPos   = 3'(bitIdx_q);
    assign byteEnd  = (bitPos == 3'd7) || (bitIdx_q == ROW_LAST);

    // State and datapath registers; reset returns every pin to its idle level at once.
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sclk_q   <= 1'b0;
            addrSh_q <= '0;
            aIdx_q   <= '0;
            bitIdx_q <= '0;
            acc_q    <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            dl_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sclk_q   <= sclk_d;
            addrSh_q <= addrSh_d;
            aIdx_q   <= aIdx_d;
            bitIdx_q <= bitIdx_d;
            acc_q    <= acc_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            dl_q     <= dl_d;
        end
    end

    // Next-state logic: SCLK phases are counted in C cycles, and a byte is only
    // published once the high phase of its last bit has finished.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sclk_d   = sclk_q;
        addrSh_d = addrSh_q;
        aIdx_d   = aIdx_q;
        bitIdx_d = bitIdx_q;
        acc_d    = acc_q;
        data_d   = data_q;
        dv_d     = dv_q;
        dl_d     = dl_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d  = S_ADDR;
                    addrSh_d = ADDR;
                    aIdx_d   = '0;
                    cnt_d    = '0;
                    sclk_d   = 1'b0;
                end
            end
            S_ADDR: begin
                if (phaseEnd) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (aIdx_q == ADDR_LAST) begin
                            state_d = S_STROBE;
                        end else begin
                            aIdx_d   = aIdx_q + AIDX_ONE;
                            addrSh_d = addrSh_q >> 1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STROBE: begin
                if (stbEnd) begin
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    acc_d    = '0;
                    state_d  = S_READ;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_READ: begin
                if (phaseEnd) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d        = 1'b1;
                        acc_d[bitPos] = SDOUT;
                    end else begin
                        sclk_d   = 1'b0;
                        bitIdx_d = bitIdx_q + BIT_ONE;
                        if (byteEnd) begin
                            data_d  = acc_q;
                            dv_d    = 1'b1;
                            dl_d    = (bitIdx_q == ROW_LAST);
                            acc_d   = '0;
                            state_d = S_HOLD;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HOLD: begin
                if (dv_q) begin
                    if (DR) begin
                        dv_d = 1'b0;
                        dl_d = 1'b0;
                    end
                end else begin
                    state_d = (bitIdx_q == ROW_DONE) ? S_IDLE : S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin drive: SDIN only carries address bits, STB is low only while strobing.
    always_comb begin
        BUSY = (state_q != S_IDLE);
        SDIN = (state_q == S_ADDR) ? addrSh_q[0] : 1'b0;
        SCLK = sclk_q;
        STB  = (state_q != S_STROBE);
        PV   = 1'b0;
        D    = data_q;
        DV   = dv_q;
        DL   = dl_q;
    end

endmodule

// File: tb/tb_gal_row_reader.sv
// tb_gal_row_reader: directed bench for gal_row_reader with a scoreboard.
// Instance 0 reads a 64-bit row at DIV=2, and instance 1 reads a 12-bit row
// at DIV=1. Each instance talks to a small device model.
module tb_gal_row_reader;

    logic       C;
    logic       RN;
    logic [1:0] start;
    logic [5:0] addr [2];
    logic [1:0] busy;
    logic [7:0] d [2];
    logic [1:0] dv;
    logic [1:0] dr;
    logic [1:0] dl;
    logic [1:0] sdin;
    logic [1:0] sclk;
    logic [1:0] stb;
    logic [1:0] pv;
    logic [1:0] sdout;

    logic [63:0] devRowA;
    logic [11:0] devRowB;
    logic [5:0]  idxA;
    logic [3:0]  idxB;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } exp_t;

    exp_t expQ [$];
    int   compared;
    int   mismatched;

    localparam logic [13:0] RESET_OUTS = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

    gal_row_reader #(.ROW_BITS(64), .ADDR_BITS(6), .DIV(2), .STB_CYCLES(2)) dutA (
        .C(C), .RN(RN), .START(start[0]), .ADDR(addr[0]), .BUSY(busy[0]),
        .D(d[0]), .DV(dv[0]), .DR(dr[0]), .DL(dl[0]), .SDIN(sdin[0]),
        .SCLK(sclk[0]), .STB(stb[0]), .PV(pv[0]), .SDOUT(sdout[0])
    );

    gal_row_reader #(.ROW_BITS(12), .ADDR_BITS(6), .DIV(1), .STB_CYCLES(2)) dutB (
        .C(C), .RN(RN), .START(start[1]), .ADDR(addr[1]), .BUSY(busy[1]),
        .D(d[1]), .DV(dv[1]), .DR(dr[1]), .DL(dl[1]), .SDIN(sdin[1]),
        .SCLK(sclk[1]), .STB(stb[1]), .PV(pv[1]), .SDOUT(sdout[1])
    );

    initial C = 1'b0;
    always #5 C = ~C;

    // Device A: the strobe loads the row at bit 0, and each SCLK rise advances one bit.
    always @(posedge sclk[0] or negedge stb[0]) begin
        if (!stb[0])
            idxA <= 6'd0;
        else if (idxA != 6'd63)
            idxA <= idxA + 6'd1;
    end

    // Device B: same shift behaviour over a 12-bit row.
    always @(posedge sclk[1] or negedge stb[1]) begin
        if (!stb[1])
            idxB <= 4'd0;
        else if (idxB != 4'd11)
            idxB <= idxB + 4'd1;
    end

    assign sdout[0] = devRowA[idxA];
    assign sdout[1] = devRowB[idxB];

    function automatic logic [13:0] outs(input int k);
        return {busy[k], dv[k], dl[k], d[k], sdin[k], sclk[k], stb[k], pv[k]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Model of the byte stream: LSB is the earliest bit, unused upper bits are zero.
    task automatic pushExpected(input logic [63:0] row, input int n);
        int   nb;
        exp_t e;
        nb = (n + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            e.data = 8'h00;
            for (int j = 0; j < 8; j++)
                if (8 * i + j < n) e.data[j] = row[8 * i + j];
            e.last = (i == nb - 1);
            expQ.push_back(e);
        end
    endtask

    // Called on a falling edge. START is raised for exactly one rising edge,
    // and the task returns on the first busy cycle.
    task automatic applyStimulus(input int k, input logic [5:0] a);
        start[k] = 1'b1;
        addr[k]  = a;
        @(negedge C);
        start[k] = 1'b0;
        addr[k]  = ~a;
    endtask

    task automatic runRow(input int k, input logic [5:0] a, input int div,
                          input int stallLen, input int expBusy, input bit reStart);
        int         busyLen, rises, runLen, shortPhases, stbLow, stbFirst;
        int         stalled, firstRise, popped, pvBad, unstable;
        bit         stallOn;
        logic [5:0] sdinSeen;
        logic       prevSclk;
        logic [7:0] heldD;
        exp_t       e;
        busyLen = 0; rises = 0; runLen = 0; shortPhases = 0; stbLow = 0; stbFirst = 0;
        stalled = 0; firstRise = 0; popped = 0; pvBad = 0; unstable = 0;
        stallOn = 1'b0; sdinSeen = '0; prevSclk = 1'b0; heldD = '0;
        dr[k] = 1'b1;
        applyStimulus(k, a);
        checkOutput("busyAtT1", 32'(busy[k]), 32'd1);
        checkOutput("sdinAtT1", 32'(sdin[k]), 32'(a[0]));
        while (busy[k] === 1'b1 && busyLen < 1000) begin
            busyLen++;
            if (sclk[k] !== prevSclk) begin
                if (sclk[k] && rises < 6) sdinSeen[rises[2:0]] = sdin[k];
                if (sclk[k] && rises == 0) firstRise = busyLen;
                if (sclk[k]) rises++;
                if (runLen < div) shortPhases++;
                runLen = 1;
            end else begin
                runLen++;
            end
            prevSclk = sclk[k];
            if (!stb[k]) begin
                if (stbLow == 0) stbFirst = busyLen;
                stbLow++;
            end
            if (pv[k] !== 1'b0) pvBad++;
            if (reStart) begin
                start[k] = (busyLen == 10);
                addr[k]  = ~a;
            end
            if (stallLen > 0) begin
                if (!stallOn && popped == 2 && !dv[k] && stalled == 0) begin
                    dr[k]   = 1'b0;
                    stallOn = 1'b1;
                end else if (stallOn && dv[k] && stalled == stallLen) begin
                    dr[k]   = 1'b1;
                    stallOn = 1'b0;
                end
            end
            if (dv[k] && !dr[k]) begin
                if (stalled == 0) heldD = d[k];
                else if (d[k] !== heldD) unstable++;
                if (sclk[k] !== 1'b0) unstable++;
                stalled++;
            end
            if (dv[k] && dr[k]) begin
                checkOutput($sformatf("queueHasByte%0d", popped), 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("byte%0d", popped), 32'({dl[k], d[k]}), 32'(e));
                end
                popped++;
            end
            @(negedge C);
        end
        start[k] = 1'b0;
        checkOutput("busyEnds", 32'(busy[k]), 32'd0);
        checkOutput("busyLen", busyLen, expBusy);
        checkOutput("sdinSeq", 32'(sdinSeen), 32'(a));
        checkOutput("firstRise", firstRise, div + 1);
        checkOutput("stbLowLen", stbLow, 2);
        checkOutput("stbStart", stbFirst, 2 * div * 6 + 1);
        checkOutput("phaseMin", shortPhases, 0);
        checkOutput("pvLow", pvBad, 0);
        checkOutput("allBytes", expQ.size(), 0);
        if (stallLen > 0) begin
            checkOutput("stallLen", stalled, stallLen);
            checkOutput("stallStable", unstable, 0);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        RN         = 1'b0;
        start      = 2'b00;
        dr         = 2'b11;
        addr[0]    = '0;
        addr[1]    = '0;
        devRowA    = 64'hC35A800100FF3CA5;
        devRowB    = 12'hFFF;

        repeat (3) @(negedge C);
        checkOutput("resetHeldA", 32'(outs(0)), 32'(RESET_OUTS));
        checkOutput("resetHeldB", 32'(outs(1)), 32'(RESET_OUTS));
        RN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge C);
            checkOutput($sformatf("idleA%0d", i), 32'(outs(0)), 32'(RESET_OUTS));
            checkOutput($sformatf("idleB%0d", i), 32'(outs(1)), 32'(RESET_OUTS));
        end

        $display("[TB] full 64-bit row with address 101101");
        pushExpected(devRowA, 64);
        runRow(0, 6'b101101, 2, 0, 298, 1'b0);

        $display("[TB] partial 12-bit row");
        pushExpected({52'd0, devRowB}, 12);
        runRow(1, 6'b110010, 1, 0, 42, 1'b0);

        $display("[TB] back-pressure on byte 3");
        pushExpected(devRowA, 64);
        runRow(0, 6'b000111, 2, 37, 335, 1'b0);

        $display("[TB] reset during READ");
        @(negedge C);
        applyStimulus(0, 6'b111000);
        repeat (39) @(negedge C);
        checkOutput("busyBeforeReset", 32'(busy[0]), 32'd1);
        #2 RN = 1'b0;
        #1 checkOutput("asyncResetA", 32'(outs(0)), 32'(RESET_OUTS));
        @(negedge C);
        checkOutput("resetHeldMid", 32'(outs(0)), 32'(RESET_OUTS));
        RN = 1'b1;
        @(negedge C);

        $display("[TB] fresh row after reset, with a START while busy");
        pushExpected(devRowA, 64);
        runRow(0, 6'b100110, 2, 0, 298, 1'b1);
        repeat (5) @(negedge C);
        checkOutput("staysIdle", 32'(busy[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
